// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and counter-width helper for the bit-serial adder.
package serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter must reach WIDTH-1, so WIDTH+1 values keeps one spare code.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_full_adder.sv
// bit_full_adder: combinational full adder from two half-adder stages plus an OR.
module bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_p;
   logic w_g;
   logic w_t;

   assign w_p  = a ^ b;
   assign w_g  = a & b;
   assign s    = w_p ^ cin;
   assign w_t  = w_p & cin;
   assign cout = w_g | w_t;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial unsigned adder, one bit per clock via a single
// full-adder cell, with a start/busy/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic [WIDTH-1:0] w_shift;

   bit_full_adder u_fa (
      .a   (r_a[0]),
      .b   (r_b[0]),
      .cin (r_carry),
      .s   (w_s),
      .cout(w_c)
   );

   // The final step's sum bit goes straight into the result, so only WIDTH-1 bits are stored.
   assign w_shift = {w_s, r_res};
   assign w_last  = r_cnt == CNT_W'(WIDTH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_a     <= a;
               r_b     <= b;
               r_res   <= '0;
               r_cnt   <= '0;
               r_carry <= 1'b0;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_res   <= w_shift[WIDTH-1:1];
               r_carry <= w_c;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_sum   <= w_shift;
                  r_cout  <= w_c;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_state == ST_RUN;
   assign done      = r_state == ST_DONE;
   assign sum       = r_sum;
   assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8 directed, WIDTH=4 exhaustive).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start4 = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       busy, done, carry_out;
   logic [7:0] sum;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic [8:0] last8 = '0;
   logic [8:0] e8;
   logic [4:0] e4;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
   );

   serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: pop the oldest expectation whenever a done pulse appears.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy_done_excl", 32'(busy & done), 32'd0);
         if (done) begin
            chk("done_has_expect", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
               e8 = q8.pop_front();
               chk("sum8", 32'({carry_out, sum}), 32'(e8));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done4) begin
         chk("done4_has_expect", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            chk("sum4", 32'({cout4, sum4}), 32'(e4));
         end
      end
   end

   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [8:0] e, input bit push);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      if (push) q8.push_back(e);
   endtask

   task automatic run_one(input string nm, input logic [7:0] x, input logic [7:0] y, input logic [8:0] e);
      int k;
      int nb;
      nb = 0;
      issue(x, y, e, 1'b1);
      for (k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 2) begin a = ~x; b = ~y; end
         if (k == 5) chk({nm, "_hold"}, 32'({carry_out, sum}), 32'(last8));
         nb += int'(busy);
         if (done) break;
      end
      chk({nm, "_latency"}, 32'(k), 32'd9);
      chk({nm, "_busy_cycles"}, 32'(nb), 32'd8);
      last8 = e;
   endtask

   typedef struct { logic [7:0] x; logic [7:0] y; logic [8:0] e; } vec_t;
   vec_t b2b[6];

   initial begin
      int k;
      b2b[0] = '{8'h7F, 8'h81, 9'h100};
      b2b[1] = '{8'hA5, 8'h5A, 9'h0FF};
      b2b[2] = '{8'hC8, 8'h64, 9'h12C};
      b2b[3] = '{8'h01, 8'h02, 9'h003};
      b2b[4] = '{8'h80, 8'h7F, 9'h0FF};
      b2b[5] = '{8'hF0, 8'h20, 9'h110};

      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", 32'({busy, done, carry_out, sum}), 32'd0);
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("idle_outputs", 32'({busy, done, carry_out, sum}), 32'd0);
      end

      run_one("basic", 8'h0F, 8'h01, 9'h010);
      run_one("ovf1", 8'hFF, 8'h01, 9'h100);
      run_one("ovf2", 8'hFF, 8'hFF, 9'h1FE);

      issue(8'h12, 8'h34, 9'h046, 1'b1);
      for (k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 4) begin a = 8'hAA; b = 8'hAA; start = 1'b1; end
         if (k == 5) start = 1'b0;
         if (done) break;
      end
      chk("ignored_latency", 32'(k), 32'd9);
      repeat (15) begin
         @(negedge clk);
         chk("ignored_no_run", 32'(busy), 32'd0);
      end
      chk("ignored_sum_held", 32'({carry_out, sum}), 32'h046);

      issue(8'h80, 8'h80, 9'h100, 1'b0);
      for (k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      chk("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_sum", 32'({carry_out, sum}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last8 = '0;
      repeat (12) begin
         @(negedge clk);
         chk("after_reset_idle", 32'({busy, done}), 32'd0);
      end
      run_one("post_reset", 8'h03, 8'h04, 9'h007);

      @(negedge clk);
      a = b2b[0].x;
      b = b2b[0].y;
      start = 1'b1;
      q8.push_back(b2b[0].e);
      for (int i = 0; i < 6; i++) begin
         for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) break;
         end
         chk("b2b_period", 32'(k), (i == 0) ? 32'd9 : 32'd10);
         if (i < 5) begin
            a = b2b[i+1].x;
            b = b2b[i+1].y;
            q8.push_back(b2b[i+1].e);
         end else start = 1'b0;
      end

      @(negedge clk);
      a4 = '0;
      b4 = '0;
      start4 = 1'b1;
      q4.push_back(5'd0);
      for (int i = 0; i < 256; i++) begin
         for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done4) break;
         end
         if (k > 20) chk("ex4_timeout", 32'(k), 32'd6);
         if (i < 255) begin
            a4 = 4'((i + 1) >> 4);
            b4 = 4'(i + 1);
            q4.push_back({1'b0, a4} + {1'b0, b4});
         end else start4 = 1'b0;
      end

      repeat (10) @(negedge clk);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit unsigned adder: the additive counterpart to the team's half_subtractor datapath.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a registered carry.
- Uses a start/busy/done handshake.
- Serves as the area-minimal arithmetic engine for the small-datapath blocks in the design; the subtractor blocks are cross-checked against it.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse; sum and carry_out are valid from this cycle on.
- sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - Internal shift registers, carry flop and counter are cleared.
- States: IDLE, RUN, DONE (encoding lives in the shared package).
- IDLE:
  - On a rising edge with start=1: load A_sr<=a, B_sr<=b, carry<=0, cnt<=0, result shift register <=0; go to RUN.
  - With start=0, stay in IDLE.
- RUN: each edge performs one bit step:
  - s = A_sr[0]^B_sr[0]^carry.
  - carry <= majority(A_sr[0],B_sr[0],carry).
  - Result shift register shifts right with s entering at the MSB.
  - A_sr and B_sr shift right, zero-filled.
  - cnt <= cnt+1.
  - When the step completes with cnt==WIDTH-1, go to DONE and copy the final result to sum and the final carry to carry_out, both on that same edge.
- DONE:
  - done=1 for exactly one cycle, then unconditionally return to IDLE.
  - start is ignored in DONE.
- busy=1 exactly in RUN. busy and done are never high together.
- Latency:
  - start accepted at edge 0.
  - RUN steps occur at edges 1..WIDTH.
  - done is high during the cycle between edge WIDTH and edge WIDTH+1.
  - The next start can be accepted at edge WIDTH+2 at the earliest.
- Held outputs:
  - sum and carry_out hold their last values from DONE until the next DONE.
  - They do not change during RUN.
- Operands: a and b may change freely after acceptance; only the captured values are used.
- start while busy or done: ignored; it is not queued.
- start held high continuously: a new addition is accepted at each IDLE visit, one per WIDTH+2 cycles.
- Arithmetic: unsigned; overflow is reported only through carry_out. There is no saturation.
- Reset during RUN: the operation is abandoned, no done pulse is produced, and sum/carry_out return to 0.

Decomposition:
- Package serial_adder_pkg holds:
  - the state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the CNT_W derivation helper.
- One sub-module, bit_full_adder: a combinational full adder built from two half-adder stages plus an OR.
  - Ports a, b, cin, s, cout.
  - Instantiated once in the datapath.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high with start=0 for 20 cycles -> busy=0, done=0, sum=8'h00, carry_out=0 throughout.
- Basic add: a=8'h0F, b=8'h01, start for one cycle -> busy high for 8 cycles; done pulses exactly 9 cycles after the start edge; sum=8'h10, carry_out=0.
- Overflow cases:
  - a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1.
  - a=8'hFF, b=8'hFF -> sum=8'hFE, carry_out=1.
- Ignored start: start a=8'h12, b=8'h34; pulse start again mid-RUN with a=8'hAA, b=8'hAA -> exactly one done, sum=8'h46; no second operation begins.
- Reset mid-operation: start a=8'h80, b=8'h80; assert rst_n low at RUN step 4 -> busy=0 immediately, no done pulse, sum=8'h00, carry_out=0. A following add of 8'h03+8'h04 gives 8'h07.
- Back-to-back and exhaustive:
  - start held high with operands changed each accept -> one done every 10 cycles, each with the correct sum.
  - Exhaustive 4-bit build (WIDTH=4): all 256 operand pairs match a+b against a reference model.
